// File: rtl/img_proc_pkg.sv
// -----------------------------------------------------------------------------
// img_proc_pkg
// Shared definitions for the image-processing slice: frame-controller state
// encoding, default active-window geometry and the pixel-count helper. The
// object detector uses the same geometry defaults so both blocks agree on
// where a frame ends.
// -----------------------------------------------------------------------------
package img_proc_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_CNT_W    = 19;   // holds H_ACTIVE_DEF*V_ACTIVE_DEF
    localparam int COORD_W      = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_ABORT   = 3'd4
    } frame_state_e;

    // Index of the last active pixel in a frame (constant-folded at elaboration).
    function automatic logic [PIX_CNT_W-1:0] pix_last(input int h, input int v);
        return PIX_CNT_W'(h * v - 1);
    endfunction

endpackage

// File: rtl/presence_debounce.sv
// -----------------------------------------------------------------------------
// presence_debounce
// Frame-rate hysteresis on the detector's presence flag. On each strobe a
// present frame bumps a saturating hit count and clears the miss count; an
// absent frame does the converse. tracking sets once PRESENT_FRAMES
// consecutive hits are seen and clears after LOST_FRAMES consecutive misses.
//
// Ports
//   iCLK, iRST    clock / async active-low reset
//   strobe        one-cycle frame-evaluation strobe
//   present       presence flag, sampled on strobe
//   tracking      registered debounced presence
//   tracking_nxt  value tracking takes at the next edge (lets the parent
//                 act on the updated decision within the strobe cycle)
// -----------------------------------------------------------------------------
module presence_debounce #(
    parameter int PRESENT_FRAMES = 3,
    parameter int LOST_FRAMES    = 5
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic strobe,
    input  logic present,
    output logic tracking,
    output logic tracking_nxt
);

    localparam int HIT_W  = $clog2(PRESENT_FRAMES + 1);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [HIT_W-1:0]  HIT_MAX  = HIT_W'(PRESENT_FRAMES);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOST_FRAMES);

    logic [HIT_W-1:0]  hit_cnt,  hit_nxt;
    logic [MISS_W-1:0] miss_cnt, miss_nxt;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        hit_nxt      = hit_cnt;
        miss_nxt     = miss_cnt;
        tracking_nxt = tracking;
        if (strobe) begin
            if (present) begin
                miss_nxt = '0;
                if (hit_cnt != HIT_MAX) hit_nxt = hit_cnt + HIT_W'(1);
            end else begin
                hit_nxt = '0;
                if (miss_cnt != MISS_MAX) miss_nxt = miss_cnt + MISS_W'(1);
            end
            if (hit_nxt == HIT_MAX)        tracking_nxt = 1'b1;
            else if (miss_nxt == MISS_MAX) tracking_nxt = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignment so all of them sample the
    // pre-edge values, independent of statement order.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            tracking <= 1'b0;
        end else begin
            hit_cnt  <= hit_nxt;
            miss_cnt <= miss_nxt;
            tracking <= tracking_nxt;
        end
    end

endmodule

// File: rtl/detect_frame_ctrl.sv
// -----------------------------------------------------------------------------
// detect_frame_ctrl
// Frame-level controller around a pixel-streaming object detector. Arms on
// iEnable, waits for a fresh frame start, forwards exactly one frame of pixels
// to the detector, then evaluates the detector result once per frame: presence
// is debounced into oTracking and, while tracking, the coordinate is published
// through a valid/ready register (latest wins, overwrite flagged on oOverrun).
// Truncated frames are aborted with a one-cycle detector reset.
//
// Ports
//   iCLK, iRST            clock / async active-low reset
//   iEnable               tracking enable (level)
//   iFVAL, iDVAL          camera frame / pixel valid
//   iRow, iCol, iPresent  detector result, sampled in EVAL
//   oDVAL                 pixel valid gated to the detector (CAPTURE only)
//   oDpRst_n              detector reset, low in IDLE and ABORT
//   oCoordValid/iCoordReady, oCoordRow/oCoordCol  published coordinate
//   oTracking             debounced presence
//   oTimeout              sticky: no frame start within TIMEOUT armed cycles
//   oOverrun              one-cycle pulse: unaccepted coordinate overwritten
//   oFrameCnt             completed-frame counter (wraps)
// -----------------------------------------------------------------------------
module detect_frame_ctrl
    import img_proc_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int PRESENT_FRAMES = 3,
    parameter int LOST_FRAMES    = 5,
    parameter int TIMEOUT        = 2000000
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEnable,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iRow,
    input  logic [COORD_W-1:0] iCol,
    input  logic               iPresent,
    output logic               oDVAL,
    output logic               oDpRst_n,
    output logic               oCoordValid,
    input  logic               iCoordReady,
    output logic [COORD_W-1:0] oCoordRow,
    output logic [COORD_W-1:0] oCoordCol,
    output logic               oTracking,
    output logic               oTimeout,
    output logic               oOverrun,
    output logic [15:0]        oFrameCnt
);

    localparam logic [PIX_CNT_W-1:0] PIX_LAST = pix_last(H_ACTIVE, V_ACTIVE);
    localparam int                   TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);

    frame_state_e         state, state_nxt;
    logic                 fval_q;
    logic                 fval_rise;
    logic                 cap_entry;
    logic                 eval_strobe;
    logic                 trk_nxt;
    logic                 publish;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic [TO_W-1:0]      to_cnt;

    // A rise needs a low sample first, so a frame already running when we
    // arm is skipped until its next start.
    assign fval_rise = iFVAL && !fval_q;

    // ---------------- state register ----------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= ST_IDLE;
            fval_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fval_q <= iFVAL;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (iEnable) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (!iEnable)       state_nxt = ST_IDLE;
                else if (fval_rise) state_nxt = ST_CAPTURE;
            end
            // Disable is ignored here: a started frame always completes.
            ST_CAPTURE: begin
                if (iDVAL && (pix_cnt == PIX_LAST)) state_nxt = ST_EVAL;
                else if (!iFVAL)                    state_nxt = ST_ABORT;
            end
            ST_EVAL,
            ST_ABORT:   state_nxt = iEnable ? ST_ARMED : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / strobe logic ----------------
    always_comb begin
        oDVAL       = 1'b0;
        oDpRst_n    = 1'b1;
        eval_strobe = 1'b0;
        case (state)
            ST_IDLE:    oDpRst_n    = 1'b0;
            ST_CAPTURE: oDVAL       = iDVAL;
            ST_EVAL:    eval_strobe = 1'b1;
            ST_ABORT:   oDpRst_n    = 1'b0;
            default:    ;
        endcase
        cap_entry = (state == ST_ARMED) && (state_nxt == ST_CAPTURE);
    end

    // ---------------- pixel counter ----------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)                                  pix_cnt <= '0;
        else if (cap_entry)                         pix_cnt <= '0;
        else if ((state == ST_CAPTURE) && iDVAL)    pix_cnt <= pix_cnt + PIX_CNT_W'(1);
    end

    // ---------------- arm timeout ----------------
    // Counter lives only in ARMED; the flag is sticky until a frame starts.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            to_cnt   <= '0;
            oTimeout <= 1'b0;
        end else begin
            if (state != ST_ARMED)   to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);

            if (cap_entry)                                     oTimeout <= 1'b0;
            else if ((state == ST_ARMED) && (to_cnt == TO_LAST)) oTimeout <= 1'b1;
        end
    end

    // ---------------- presence hysteresis ----------------
    presence_debounce #(
        .PRESENT_FRAMES (PRESENT_FRAMES),
        .LOST_FRAMES    (LOST_FRAMES)
    ) u_debounce (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .strobe       (eval_strobe),
        .present      (iPresent),
        .tracking     (oTracking),
        .tracking_nxt (trk_nxt)
    );

    // Publish uses the post-update tracking decision of this very frame.
    assign publish = eval_strobe && trk_nxt && iPresent;

    // ---------------- coordinate handshake + frame count ----------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oCoordValid <= 1'b0;
            oCoordRow   <= '0;
            oCoordCol   <= '0;
            oOverrun    <= 1'b0;
            oFrameCnt   <= '0;
        end else begin
            if (publish) begin
                oCoordRow   <= iRow;
                oCoordCol   <= iCol;
                oCoordValid <= 1'b1;
                oOverrun    <= oCoordValid && !iCoordReady;
            end else begin
                oOverrun <= 1'b0;
                if (iCoordReady) oCoordValid <= 1'b0;
            end
            if (eval_strobe) oFrameCnt <= oFrameCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_detect_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_detect_frame_ctrl
// Self-checking bench for detect_frame_ctrl on a reduced 16x8 window with
// TIMEOUT=100. The reference keeps frame-level state: a history of presence
// results (tracking derived from trailing run lengths), the expected frame
// count and the coordinate register contents.
// -----------------------------------------------------------------------------
module tb_detect_frame_ctrl;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int TOTAL = H * V;
    localparam int P     = 3;
    localparam int L     = 5;
    localparam int TO    = 100;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iEnable, iFVAL, iDVAL, iPresent, iCoordReady;
    logic [10:0] iRow, iCol;
    logic        oDVAL, oDpRst_n, oCoordValid, oTracking, oTimeout, oOverrun;
    logic [10:0] oCoordRow, oCoordCol;
    logic [15:0] oFrameCnt;

    detect_frame_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PRESENT_FRAMES(P),
        .LOST_FRAMES(L), .TIMEOUT(TO)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iFVAL(iFVAL),
        .iDVAL(iDVAL), .iRow(iRow), .iCol(iCol), .iPresent(iPresent),
        .oDVAL(oDVAL), .oDpRst_n(oDpRst_n), .oCoordValid(oCoordValid),
        .iCoordReady(iCoordReady), .oCoordRow(oCoordRow), .oCoordCol(oCoordCol),
        .oTracking(oTracking), .oTimeout(oTimeout), .oOverrun(oOverrun),
        .oFrameCnt(oFrameCnt)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_frames;
    logic        exp_trk, exp_valid, exp_ovr, exp_timeout;
    logic [10:0] exp_row, exp_col;
    logic        hist[$];
    logic        pub_now;
    logic [10:0] pub_row, pub_col;

    task automatic model_reset();
        exp_frames = '0; exp_trk = 1'b0; exp_valid = 1'b0; exp_ovr = 1'b0;
        exp_timeout = 1'b0; exp_row = '0; exp_col = '0; pub_now = 1'b0;
        hist.delete();
    endtask

    // Tracking from the trailing run of identical presence results.
    function automatic logic model_tracking(input logic prev);
        int   run;
        logic last;
        run = 0;
        if (hist.size() == 0) return prev;
        last = hist[hist.size()-1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != last) break;
            run++;
        end
        if (last && run >= P)  return 1'b1;
        if (!last && run >= L) return 1'b0;
        return prev;
    endfunction

    // One clock edge; the coordinate register model follows the handshake.
    task automatic step();
        @(posedge iCLK);
        if (pub_now) begin
            exp_ovr   = exp_valid && !iCoordReady;
            exp_valid = 1'b1;
            exp_row   = pub_row;
            exp_col   = pub_col;
        end else begin
            exp_ovr = 1'b0;
            if (iCoordReady) exp_valid = 1'b0;
        end
        pub_now = 1'b0;
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".frames"},   oFrameCnt,   exp_frames);
        check({tag, ".tracking"}, oTracking,   exp_trk);
        check({tag, ".valid"},    oCoordValid, exp_valid);
        check({tag, ".row"},      oCoordRow,   exp_row);
        check({tag, ".col"},      oCoordCol,   exp_col);
        check({tag, ".overrun"},  oOverrun,    exp_ovr);
        check({tag, ".timeout"},  oTimeout,    exp_timeout);
    endtask

    // Idle with iFVAL low: pixel valid must never reach the detector.
    task automatic idle(input int n);
        iFVAL = 1'b0;
        repeat (n) begin
            iDVAL = 1'($urandom_range(0, 1));
            @(negedge iCLK);
            check("dval_idle", oDVAL, 0);
            step();
        end
        iDVAL = 1'b0;
    endtask

    // One frame from a fresh iFVAL rise; npix < TOTAL truncates it (abort).
    task automatic run_frame(input int npix, input logic pres, input logic [10:0] r,
                             input logic [10:0] c, input logic rdy, input logic rdy_eval,
                             input logic drop_en);
        iRow = r; iCol = c; iPresent = pres; iCoordReady = rdy;
        iFVAL = 1'b1; iDVAL = 1'b1;
        @(negedge iCLK);
        check("dval_on_rise", oDVAL, 0);
        step();
        exp_timeout = 1'b0;
        check("timeout_clr", oTimeout, exp_timeout);
        check("dprst_capture", oDpRst_n, 1);
        for (int p = 0; p < npix; p++) begin
            iDVAL = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            iDVAL = 1'b1;
            if (drop_en && p == npix / 2) iEnable = 1'b0;
            @(negedge iCLK);
            check("dval_pass", oDVAL, 1);
            step();
        end
        iDVAL = 1'b0;
        if (npix >= TOTAL) begin
            iDVAL = 1'($urandom_range(0, 1));
            iCoordReady = rdy_eval;
            @(negedge iCLK);
            check("dval_eval", oDVAL, 0);
            hist.push_back(pres);
            exp_trk = model_tracking(exp_trk);
            exp_frames = exp_frames + 16'd1;
            if (exp_trk && pres) begin
                pub_now = 1'b1; pub_row = r; pub_col = c;
            end
            step();
            iFVAL = 1'b0; iDVAL = 1'b0; iCoordReady = rdy;
            check_state("eval");
            check("dprst_after_eval", oDpRst_n, iEnable);
            step();
            check_state("post_eval");
        end else begin
            iFVAL = 1'b0;
            step();
            iDVAL = 1'b1;
            @(negedge iCLK);
            check("dprst_abort", oDpRst_n, 0);
            check("dval_abort", oDVAL, 0);
            step();
            iDVAL = 1'b0;
            check("dprst_after_abort", oDpRst_n, iEnable);
            check_state("abort");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          kind;
        logic        pres, rdy, rdye;
        logic [10:0] r, c;

        model_reset();
        iRST = 1'b0; iEnable = 1'b0; iFVAL = 1'b0; iDVAL = 1'b1;
        iRow = '0; iCol = '0; iPresent = 1'b0; iCoordReady = 1'b0;
        #12;
        check("rst_dval", oDVAL, 0);
        check("rst_dprst", oDpRst_n, 0);
        check_state("rst");
        iDVAL = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        step();
        check("idle_dprst", oDpRst_n, 0);
        iEnable = 1'b1;
        step();
        check("armed_dprst", oDpRst_n, 1);
        idle(3);

        // Two present frames: counting, not yet tracking; third publishes.
        iCoordReady = 1'b1;
        run_frame(TOTAL, 1'b1, 11'd240, 11'd320, 1'b1, 1'b1, 1'b0);
        idle(2);
        run_frame(TOTAL, 1'b1, 11'd240, 11'd320, 1'b1, 1'b1, 1'b0);
        check("two_frames_cnt", oFrameCnt, 2);
        check("two_frames_trk", oTracking, 0);
        idle(2);
        run_frame(TOTAL, 1'b1, 11'd240, 11'd320, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Unaccepted publish overwritten by the next one.
        run_frame(TOTAL, 1'b1, 11'd100, 11'd200, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_frame(TOTAL, 1'b1, 11'd110, 11'd210, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Publish with pending data accepted in the same cycle.
        run_frame(TOTAL, 1'b1, 11'd120, 11'd220, 1'b0, 1'b1, 1'b0);
        iCoordReady = 1'b1;
        idle(2);
        check_state("drain");

        // Four absent frames then a present one keeps tracking; then five absent.
        repeat (4) begin
            run_frame(TOTAL, 1'b0, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b1, 1'b1, 1'b0);
            idle(1);
        end
        run_frame(TOTAL, 1'b1, 11'd55, 11'd66, 1'b1, 1'b1, 1'b0);
        idle(1);
        repeat (5) begin
            run_frame(TOTAL, 1'b0, 11'd1, 11'd2, 1'b1, 1'b1, 1'b0);
            idle(1);
        end
        check("lost_after_5", oTracking, 0);

        // Truncated frame aborts; following full frame counts normally.
        run_frame(100, 1'b1, 11'd7, 11'd8, 1'b1, 1'b1, 1'b0);
        idle(3);
        run_frame(TOTAL, 1'b0, 11'd7, 11'd8, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Arm timeout: 100 armed cycles without a frame start.
        iEnable = 1'b0;
        step();
        check("to_idle_dprst", oDpRst_n, 0);
        iEnable = 1'b1;
        step();
        repeat (TO - 1) step();
        check("timeout_pre", oTimeout, 0);
        step();
        exp_timeout = 1'b1;
        check("timeout_set", oTimeout, exp_timeout);
        idle(3);
        check("timeout_sticky", oTimeout, exp_timeout);
        run_frame(TOTAL, 1'b1, 11'd9, 11'd9, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Randomized frames: presence, coordinates, ready, aborts, disable mid-frame.
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 7);
            pres = ($urandom_range(0, 3) != 0);
            rdy  = 1'($urandom_range(0, 1));
            rdye = 1'($urandom_range(0, 1));
            r    = 11'($urandom_range(0, 2047));
            c    = 11'($urandom_range(0, 2047));
            if (kind == 0) begin
                run_frame($urandom_range(1, TOTAL - 1), pres, r, c, rdy, rdye, 1'b0);
            end else if (kind == 1) begin
                run_frame(TOTAL, pres, r, c, rdy, rdye, 1'b1);
                check("disabled_idle_dprst", oDpRst_n, 0);
                iEnable = 1'b1;
                step();
            end else begin
                run_frame(TOTAL, pres, r, c, rdy, rdye, 1'b0);
            end
            idle($urandom_range(1, 4));
        end

        // Reset in the middle of a capture with a coordinate pending.
        repeat (3) begin
            run_frame(TOTAL, 1'b1, 11'd300, 11'd400, 1'b0, 1'b0, 1'b0);
            idle(1);
        end
        iFVAL = 1'b1;
        step();
        repeat (20) begin
            iDVAL = 1'b1;
            step();
        end
        #2;
        iRST = 1'b0;
        #1;
        model_reset();
        check("midrst_dval", oDVAL, 0);
        check("midrst_dprst", oDpRst_n, 0);
        check_state("midrst");
        iFVAL = 1'b0; iDVAL = 1'b0; iCoordReady = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        step();
        check("after_rst_dprst", oDpRst_n, 1);
        idle(2);
        run_frame(TOTAL, 1'b1, 11'd12, 11'd34, 1'b1, 1'b1, 1'b0);
        check("after_rst_frames", oFrameCnt, 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
